// File: rtl/bdi_pkg.sv
// Shared BDI encoding constants, candidate table and compressor FSM states.
// Imported by both the line compressor and the compressed-size decoder.
package bdi_pkg;

    localparam logic [3:0] ENC_ZERO   = 4'd0;
    localparam logic [3:0] ENC_B8D1   = 4'd2;
    localparam logic [3:0] ENC_B8D2   = 4'd3;
    localparam logic [3:0] ENC_B8D4   = 4'd4;
    localparam logic [3:0] ENC_B4D1   = 4'd5;
    localparam logic [3:0] ENC_B4D2   = 4'd6;
    localparam logic [3:0] ENC_B2D1   = 4'd7;
    localparam logic [3:0] ENC_UNCOMP = 4'd15;

    localparam logic [8:0] SIZE_ZERO   = 9'd1;
    localparam logic [8:0] SIZE_B8D1   = 9'd96;
    localparam logic [8:0] SIZE_B8D2   = 9'd128;
    localparam logic [8:0] SIZE_B8D4   = 9'd192;
    localparam logic [8:0] SIZE_B4D1   = 9'd96;
    localparam logic [8:0] SIZE_B4D2   = 9'd160;
    localparam logic [8:0] SIZE_B2D1   = 9'd144;
    localparam logic [8:0] SIZE_UNCOMP = 9'd256;

    localparam logic [2:0] K_LAST     = 3'd6;
    localparam logic [2:0] K_FALLBACK = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        PACK,
        OUT
    } bdi_state_e;

    // Indexed by k in ascending compressed-size order; slot 7 is the uncompressed fallback.
    localparam logic [3:0] CAND_ENC [8] = '{ENC_ZERO, ENC_B8D1, ENC_B4D1, ENC_B8D2,
                                            ENC_B2D1, ENC_B4D2, ENC_B8D4, ENC_UNCOMP};
    localparam logic [8:0] CAND_SIZE [8] = '{SIZE_ZERO, SIZE_B8D1, SIZE_B4D1, SIZE_B8D2,
                                             SIZE_B2D1, SIZE_B4D2, SIZE_B8D4, SIZE_UNCOMP};
    localparam int unsigned CAND_B [8] = '{0, 8, 4, 8, 2, 4, 8, 0};
    localparam int unsigned CAND_D [8] = '{0, 1, 1, 2, 1, 2, 4, 0};

endpackage

// File: rtl/bdi_delta_check.sv
// Combinational base/delta fit test and payload packing for one B-byte base,
// D-byte delta candidate over a 256-bit line.
module bdi_delta_check #(
    parameter int unsigned B = 8,
    parameter int unsigned D = 1
) (
    input  logic [255:0] line,
    output logic         fit,
    output logic [255:0] payload
);

    localparam int unsigned EW = 8 * B;
    localparam int unsigned DW = 8 * D;
    localparam int unsigned N  = 256 / EW;

    logic [EW-1:0] base;
    logic [EW-1:0] delta;

    always_comb begin
        base    = line[EW-1:0];
        delta   = '0;
        fit     = 1'b1;
        payload = '0;
        payload[EW-1:0] = base;
        for (int unsigned i = 0; i < N; i++) begin
            delta = line[i*EW +: EW] - base;
            // Lossless iff the upper bits are a pure sign extension of the low DW bits.
            if (delta != {{(EW-DW){delta[DW-1]}}, delta[DW-1:0]})
                fit = 1'b0;
            payload[EW + i*DW +: DW] = delta[DW-1:0];
        end
    end

endmodule

// File: rtl/bdi_line_compressor.sv
// Base-delta-immediate compressor for 256-bit cache lines, one line in flight.
// Macro BDI_EARLY_EXIT_EN: leave EVAL on the first fit instead of scanning all candidates.
module bdi_line_compressor
    import bdi_pkg::*;
#(
    parameter int unsigned LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LINE_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_encoding,
    output logic [8:0]           out_size,
    output logic [LINE_BITS-1:0] out_data
);

    bdi_state_e           state;
    bdi_state_e           state_nxt;
    logic [2:0]           k;
    logic [2:0]           sel;
    logic [2:0]           pick;
    logic                 found;
    logic [LINE_BITS-1:0] line_q;
    logic [7:0]           fit;
    logic [LINE_BITS-1:0] payload [8];

    assign fit[0]     = (line_q == '0);
    assign fit[7]     = 1'b0;
    assign payload[0] = '0;
    assign payload[7] = line_q;

    for (genvar g = 1; g < 7; g++) begin : g_cand
        bdi_delta_check #(
            .B(CAND_B[g]),
            .D(CAND_D[g])
        ) u_chk (
            .line    (line_q),
            .fit     (fit[g]),
            .payload (payload[g])
        );
    end

    assign pick = found ? sel : K_FALLBACK;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = EVAL;
`ifdef BDI_EARLY_EXIT_EN
            EVAL: if (fit[k] || k == K_LAST) state_nxt = PACK;
`else
            EVAL: if (k == K_LAST) state_nxt = PACK;
`endif
            PACK: state_nxt = OUT;
            OUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k            <= '0;
            sel          <= '0;
            found        <= 1'b0;
            line_q       <= '0;
            out_encoding <= ENC_UNCOMP;
            out_size     <= '0;
            out_data     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    line_q <= in_data;
                    k      <= '0;
                    found  <= 1'b0;
                end
                EVAL: begin
                    // First fit wins; later fits in the full-scan mode are ignored.
                    if (!found && fit[k]) begin
                        found <= 1'b1;
                        sel   <= k;
                    end
                    if (k != K_LAST) k <= k + 3'd1;
                end
                PACK: begin
                    out_encoding <= CAND_ENC[pick];
                    out_size     <= CAND_SIZE[pick];
                    out_data     <= payload[pick];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bdi_line_compressor.sv
// Self-checking bench for bdi_line_compressor against an arithmetic BDI model.
// Honors BDI_EARLY_EXIT_EN for the expected latency.
module tb_bdi_line_compressor;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_encoding;
    logic [8:0]   out_size;
    logic [255:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    int m_enc  [6] = '{2, 5, 3, 7, 6, 4};
    int m_b    [6] = '{8, 4, 8, 2, 4, 8};
    int m_d    [6] = '{1, 1, 2, 1, 2, 4};
    int m_size [6] = '{96, 96, 128, 144, 160, 192};

    always #5 clk = ~clk;

    bdi_line_compressor #(.LINE_BITS(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_encoding (out_encoding),
        .out_size     (out_size),
        .out_data     (out_data)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [255:0] l, output logic [3:0] enc,
                                  output logic [8:0] sz, output logic [255:0] d, output int ksel);
        int ew, dw;
        logic [63:0] mask, dmask, base, e, dd;
        logic [255:0] pk;
        longint sv, lim;
        bit ok;
        enc = 4'd15; sz = 9'd256; d = l; ksel = 7;
        if (l == '0) begin
            enc = 4'd0; sz = 9'd1; d = '0; ksel = 0;
            return;
        end
        for (int c = 0; c < 6; c++) begin
            ew    = 8 * m_b[c];
            dw    = 8 * m_d[c];
            mask  = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
            dmask = (64'd1 << dw) - 64'd1;
            lim   = longint'(1) << (dw - 1);
            base  = l[63:0] & mask;
            pk    = 256'(base);
            ok    = 1'b1;
            for (int i = 0; i < 256 / ew; i++) begin
                e  = 64'(l >> (i * ew)) & mask;
                dd = (e - base) & mask;
                sv = longint'(dd << (64 - ew));
                sv = sv >>> (64 - ew);
                if (sv < -lim || sv >= lim) ok = 1'b0;
                pk = pk | (256'(dd & dmask) << (ew + i * dw));
            end
            if (ok) begin
                enc = 4'(m_enc[c]); sz = 9'(m_size[c]); d = pk; ksel = c + 1;
                return;
            end
        end
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [255:0] gen_line();
        logic [255:0] l;
        int s, bb, dsz, ew, dw;
        logic [63:0] mask, base, v, dl;
        longint t;
        s = int'($urandom_range(0, 9));
        if (s == 0) return '0;
        if (s == 1) return rand_line();
        bb  = (s % 3 == 0) ? 8 : ((s % 3 == 1) ? 4 : 2);
        dsz = (bb == 2) ? 1 : ((bb == 4) ? int'($urandom_range(1, 2)) : (1 << $urandom_range(0, 2)));
        ew  = 8 * bb;
        dw  = 8 * dsz;
        mask = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
        base = {$urandom, $urandom};
        base = base & mask;
        l = '0;
        for (int i = 0; i < 256 / ew; i++) begin
            dl = {$urandom, $urandom};
            t  = longint'(dl << (64 - dw));
            t  = t >>> (64 - dw);
            dl = 64'(t);
            if ($urandom_range(0, 15) == 0) dl = {$urandom, $urandom};
            v = (i == 0) ? base : ((base + dl) & mask);
            l = l | (256'(v) << (i * ew));
        end
        return l;
    endfunction

    task automatic run(input logic [255:0] line, input int hold, input bit pre_ready);
        logic [3:0] e_enc;
        logic [8:0] e_sz;
        logic [255:0] e_d;
        int ks, n, lat;
        model(line, e_enc, e_sz, e_d, ks);
`ifdef BDI_EARLY_EXIT_EN
        lat = 3 + ((ks > 6) ? 6 : ks);
`else
        lat = 9;
`endif
        chk("in_ready_idle", in_ready, 1'b1);
        in_valid  = 1'b1;
        in_data   = line;
        out_ready = pre_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand_line();
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("encoding", out_encoding, e_enc);
        chk("size", out_size, e_sz);
        chk("data", out_data, e_d);
        if (!pre_ready) begin
            for (int c = 0; c < hold; c++) begin
                in_valid = 1'b1;
                in_data  = rand_line();
                @(posedge clk); #1;
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_in_ready", in_ready, 1'b0);
                chk("hold_encoding", out_encoding, e_enc);
                chk("hold_size", out_size, e_sz);
                chk("hold_data", out_data, e_d);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("done_valid", out_valid, 1'b0);
        chk("done_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] l;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_encoding", out_encoding, 4'd15);
        chk("rst_size", out_size, 9'd0);
        chk("rst_data", out_data, 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run('0, 0, 1'b0);

        l = {64'h107F, 64'h0FFF, 64'h1001, 64'h1000};
        run(l, 5, 1'b0);
        chk("b8d1_enc", out_encoding, 4'd2);
        chk("b8d1_size", out_size, 9'd96);
        l = out_data;
        chk("b8d1_deltas", l[95:64], 32'h7FFF_0100);

        l = {64'h1000, 64'h1000, 64'h1080, 64'h1000};
        run(l, 0, 1'b1);
        chk("b8d2_enc", out_encoding, 4'd3);
        chk("b8d2_size", out_size, 9'd128);
        l = out_data;
        chk("b8d2_delta1", l[95:80], 16'h0080);

        l = rand_line();
        run(l, 1, 1'b0);
        chk("uncomp_enc", out_encoding, 4'd15);
        chk("uncomp_data", out_data, l);

        in_valid = 1'b1;
        in_data  = rand_line();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstpulse_out_valid", out_valid, 1'b0);
        chk("rstpulse_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rstpulse_idle", in_ready, 1'b1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rstpulse_discard", seen, 1'b0);

        run({64'h107F, 64'h0FFF, 64'h1001, 64'h1000}, 0, 1'b0);

        for (int t = 0; t < 40; t++)
            run(gen_line(), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
